// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : ID/EX pipeline register and ALU operand-select stage for the
//                pipelined MIPS datapath. Captures decoded fields from ID,
//                supports stall (hold) and flush (bubble), and presents the
//                ALU opcode, A, B and shamt. Operand forwarding from EX/MEM and
//                MEM/WB is built only when ID_EX_FORWARDING_EN is defined;
//                otherwise the forwarding ports are present but ignored.
//  Ports       : clk, reset (async, active-low), stall, flush
//                id_*      : decoded instruction fields from ID
//                ex_mem_*  : EX/MEM writeback target and ALU result
//                mem_wb_*  : MEM/WB writeback target and data
//                ex_*      : registered control + combinational operands
//  Macro       : ID_EX_FORWARDING_EN (optional, enables forwarding muxes)
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   input  logic         id_valid,
   input  logic [3:0]   id_alu_operation,
   input  logic         id_alu_src,
   input  logic         id_reg_write,
   input  logic         id_mem_read,
   input  logic         id_mem_write,
   input  logic         id_mem_to_reg,
   input  logic [N-1:0] id_read_data_1,
   input  logic [N-1:0] id_read_data_2,
   input  logic [N-1:0] id_immediate,
   input  logic [4:0]   id_shamt,
   input  logic [4:0]   id_rs,
   input  logic [4:0]   id_rt,
   input  logic [4:0]   id_write_register,
   input  logic         ex_mem_reg_write,
   input  logic [4:0]   ex_mem_write_register,
   input  logic [N-1:0] ex_mem_alu_result,
   input  logic         mem_wb_reg_write,
   input  logic [4:0]   mem_wb_write_register,
   input  logic [N-1:0] mem_wb_write_data,
   output logic         ex_valid,
   output logic [3:0]   ex_alu_operation,
   output logic [4:0]   ex_shamt,
   output logic [N-1:0] ex_a,
   output logic [N-1:0] ex_b,
   output logic [N-1:0] ex_store_data,
   output logic [4:0]   ex_write_register,
   output logic         ex_reg_write,
   output logic         ex_mem_read,
   output logic         ex_mem_write,
   output logic         ex_mem_to_reg
);

   logic         r_valid;
   logic         r_reg_write;
   logic         r_mem_read;
   logic         r_mem_write;
   logic         r_mem_to_reg;
   logic [3:0]   r_alu_operation;
   logic         r_alu_src;
   logic [4:0]   r_shamt;
   logic [4:0]   r_rs;
   logic [4:0]   r_rt;
   logic [4:0]   r_write_register;
   logic [N-1:0] r_rd1;
   logic [N-1:0] r_rd2;
   logic [N-1:0] r_immediate;

   logic [N-1:0] w_a;
   logic [N-1:0] w_store;

   // Stage register: flush beats stall beats load. A bubble clears every
   // field, including the operand data, so the ALU sees AND 0,0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid          <= 1'b0;
         r_reg_write      <= 1'b0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_to_reg     <= 1'b0;
         r_alu_operation  <= 4'd0;
         r_alu_src        <= 1'b0;
         r_shamt          <= 5'd0;
         r_rs             <= 5'd0;
         r_rt             <= 5'd0;
         r_write_register <= 5'd0;
         r_rd1            <= '0;
         r_rd2            <= '0;
         r_immediate      <= '0;
      end else if (flush) begin
         r_valid          <= 1'b0;
         r_reg_write      <= 1'b0;
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_to_reg     <= 1'b0;
         r_alu_operation  <= 4'd0;
         r_alu_src        <= 1'b0;
         r_shamt          <= 5'd0;
         r_rs             <= 5'd0;
         r_rt             <= 5'd0;
         r_write_register <= 5'd0;
         r_rd1            <= '0;
         r_rd2            <= '0;
         r_immediate      <= '0;
      end else if (!stall) begin
         r_valid          <= id_valid;
         // An invalid slot must never cause a register or memory write.
         r_reg_write      <= id_reg_write  & id_valid;
         r_mem_read       <= id_mem_read   & id_valid;
         r_mem_write      <= id_mem_write  & id_valid;
         r_mem_to_reg     <= id_mem_to_reg & id_valid;
         r_alu_operation  <= id_alu_operation;
         r_alu_src        <= id_alu_src;
         r_shamt          <= id_shamt;
         r_rs             <= id_rs;
         r_rt             <= id_rt;
         r_write_register <= id_write_register;
         r_rd1            <= id_read_data_1;
         r_rd2            <= id_read_data_2;
         r_immediate      <= id_immediate;
      end
   end

`ifdef ID_EX_FORWARDING_EN
   // EX/MEM is the younger producer, so it is checked first. Register 0 is
   // hard-wired zero and is never forwarded. Evaluated every cycle, so a held
   // instruction picks up results that arrive while it is stalled.
   always_comb begin
      w_a = r_rd1;
      if (ex_mem_reg_write && (ex_mem_write_register != 5'd0) &&
          (ex_mem_write_register == r_rs))
         w_a = ex_mem_alu_result;
      else if (mem_wb_reg_write && (mem_wb_write_register != 5'd0) &&
               (mem_wb_write_register == r_rs))
         w_a = mem_wb_write_data;
   end

   always_comb begin
      w_store = r_rd2;
      if (ex_mem_reg_write && (ex_mem_write_register != 5'd0) &&
          (ex_mem_write_register == r_rt))
         w_store = ex_mem_alu_result;
      else if (mem_wb_reg_write && (mem_wb_write_register != 5'd0) &&
               (mem_wb_write_register == r_rt))
         w_store = mem_wb_write_data;
   end
`else
   // Without forwarding the hazard unit stalls on every RAW hazard, so the
   // register-file values are always current.
   assign w_a     = r_rd1;
   assign w_store = r_rd2;

   // Forwarding ports and source-register fields are kept for interface
   // compatibility but have no function in this build.
   logic w_unused_fwd;
   assign w_unused_fwd = ^{ex_mem_reg_write, ex_mem_write_register,
                           ex_mem_alu_result, mem_wb_reg_write,
                           mem_wb_write_register, mem_wb_write_data,
                           r_rs, r_rt};
`endif

   assign ex_valid          = r_valid;
   assign ex_alu_operation  = r_alu_operation;
   assign ex_shamt          = r_shamt;
   assign ex_write_register = r_write_register;
   assign ex_reg_write      = r_reg_write;
   assign ex_mem_read       = r_mem_read;
   assign ex_mem_write      = r_mem_write;
   assign ex_mem_to_reg     = r_mem_to_reg;
   assign ex_a              = w_a;
   assign ex_store_data     = w_store;
   assign ex_b              = r_alu_src ? r_immediate : w_store;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Directed testbench for id_ex_operand_stage. A slot model
//                tracks which instruction sits in EX and derives the expected
//                outputs on every falling edge; literal checks pin key values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         stall, flush, id_valid;
   logic [3:0]   id_alu_operation;
   logic         id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic [N-1:0] id_read_data_1, id_read_data_2, id_immediate;
   logic [4:0]   id_shamt, id_rs, id_rt, id_write_register;
   logic         ex_mem_reg_write;
   logic [4:0]   ex_mem_write_register;
   logic [N-1:0] ex_mem_alu_result;
   logic         mem_wb_reg_write;
   logic [4:0]   mem_wb_write_register;
   logic [N-1:0] mem_wb_write_data;
   logic         ex_valid;
   logic [3:0]   ex_alu_operation;
   logic [4:0]   ex_shamt;
   logic [N-1:0] ex_a, ex_b, ex_store_data;
   logic [4:0]   ex_write_register;
   logic         ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage #(.N(N)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alu_operation(id_alu_operation),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .id_read_data_1(id_read_data_1),
      .id_read_data_2(id_read_data_2), .id_immediate(id_immediate),
      .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
      .id_write_register(id_write_register),
      .ex_mem_reg_write(ex_mem_reg_write),
      .ex_mem_write_register(ex_mem_write_register),
      .ex_mem_alu_result(ex_mem_alu_result),
      .mem_wb_reg_write(mem_wb_reg_write),
      .mem_wb_write_register(mem_wb_write_register),
      .mem_wb_write_data(mem_wb_write_data),
      .ex_valid(ex_valid), .ex_alu_operation(ex_alu_operation),
      .ex_shamt(ex_shamt), .ex_a(ex_a), .ex_b(ex_b),
      .ex_store_data(ex_store_data), .ex_write_register(ex_write_register),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
   );

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // The instruction currently occupying EX, as decoded by ID.
   typedef struct packed {
      logic         valid;
      logic [3:0]   op;
      logic         src;
      logic         rw, mr, mw, mtr;
      logic [4:0]   sh, rs, rt, wr;
      logic [N-1:0] rd1, rd2, imm;
   } slot_t;

   slot_t slot;

   always @(posedge clk or negedge reset) begin
      if (!reset || (reset && flush)) slot <= '0;
      else if (!stall)
         slot <= '{valid: id_valid, op: id_alu_operation, src: id_alu_src,
                   rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                   mtr: id_mem_to_reg, sh: id_shamt, rs: id_rs, rt: id_rt,
                   wr: id_write_register, rd1: id_read_data_1,
                   rd2: id_read_data_2, imm: id_immediate};
   end

   // Value a source register must take given the in-flight writebacks.
   function automatic logic [N-1:0] operand(input logic [4:0] r, input logic [N-1:0] rf);
`ifdef ID_EX_FORWARDING_EN
      if (r != 0 && ex_mem_reg_write && ex_mem_write_register == r) return ex_mem_alu_result;
      if (r != 0 && mem_wb_reg_write && mem_wb_write_register == r) return mem_wb_write_data;
`endif
      return rf;
   endfunction

   always @(negedge clk) begin
      logic [N-1:0] st;
      st = operand(slot.rt, slot.rd2);
      chk("valid", N'(ex_valid), N'(slot.valid));
      chk("opcode", N'(ex_alu_operation), N'(slot.op));
      chk("shamt", N'(ex_shamt), N'(slot.sh));
      chk("wreg", N'(ex_write_register), N'(slot.wr));
      chk("reg_write", N'(ex_reg_write), N'(slot.rw & slot.valid));
      chk("mem_read", N'(ex_mem_read), N'(slot.mr & slot.valid));
      chk("mem_write", N'(ex_mem_write), N'(slot.mw & slot.valid));
      chk("mem_to_reg", N'(ex_mem_to_reg), N'(slot.mtr & slot.valid));
      chk("a", ex_a, operand(slot.rs, slot.rd1));
      chk("store", ex_store_data, st);
      chk("b", ex_b, slot.src ? slot.imm : st);
   end

   task automatic load(input logic [3:0] op, input logic src, input logic [N-1:0] rd1,
                       input logic [N-1:0] rd2, input logic [N-1:0] imm,
                       input logic [4:0] sh, input logic [4:0] rs);
      id_valid = 1'b1; id_alu_operation = op; id_alu_src = src;
      id_read_data_1 = rd1; id_read_data_2 = rd2; id_immediate = imm;
      id_shamt = sh; id_rs = rs; id_rt = 5'd9; id_write_register = 5'd3;
      id_reg_write = 1'b1; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic edge1();
      @(posedge clk); #1;
   endtask

   logic fwd;

   initial begin
`ifdef ID_EX_FORWARDING_EN
      fwd = 1'b1;
`else
      fwd = 1'b0;
`endif
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      load(4'd0, 1'b0, '0, '0, '0, 5'd0, 5'd0);
      id_valid = 1'b0; id_reg_write = 1'b0; id_rt = 5'd0; id_write_register = 5'd0;
      ex_mem_reg_write = 1'b0; ex_mem_write_register = 5'd0; ex_mem_alu_result = '0;
      mem_wb_reg_write = 1'b0; mem_wb_write_register = 5'd0; mem_wb_write_data = '0;
      edge1(); edge1();
      chk("reset_valid", N'(ex_valid), 0);
      chk("reset_a", ex_a, 0);

      // Release reset and present ADD 5,7.
      #1 reset = 1'b1;
      load(4'd3, 1'b0, 32'd5, 32'd7, 32'h0, 5'd0, 5'd1);
      #1;
      chk("pre_edge_op", N'(ex_alu_operation), 0);
      chk("pre_edge_b", ex_b, 0);
      edge1();
      chk("add_op", N'(ex_alu_operation), 3);
      chk("add_a", ex_a, 5);
      chk("add_b", ex_b, 7);
      chk("add_rw", N'(ex_reg_write), 1);

      // SLL by 4, then LUI with immediate.
      #1 load(4'd6, 1'b0, 32'h10, 32'h1, 32'h0, 5'd4, 5'd1);
      edge1();
      chk("sll_b", ex_b, 32'h1);
      chk("sll_shamt", N'(ex_shamt), 4);
      #1 load(4'd7, 1'b1, 32'h0, 32'h55, 32'h1234, 5'd0, 5'd1);
      edge1();
      chk("lui_b", ex_b, 32'h1234);
      chk("lui_store", ex_store_data, 32'h55);

      // Hold a SUB for three cycles while ID keeps changing.
      #1 load(4'd4, 1'b0, 32'd9, 32'd3, 32'h0, 5'd0, 5'd1);
      edge1();
      for (int i = 0; i < 3; i++) begin
         #1 stall = 1'b1;
         load(4'(i), 1'b1, 32'(100 + i), 32'(200 + i), 32'hFFFF, 5'(i + 1), 5'd2);
         edge1();
         chk("stall_op", N'(ex_alu_operation), 4);
         chk("stall_a", ex_a, 9);
      end
      #1 flush = 1'b1;
      edge1();
      chk("flush_valid", N'(ex_valid), 0);
      chk("flush_rw", N'(ex_reg_write), 0);
      chk("flush_op", N'(ex_alu_operation), 0);
      chk("flush_b", ex_b, 0);

      // Forwarding priority on rs = r8 with rd1 = 1, held by stall.
      #1 flush = 1'b0; stall = 1'b0;
      load(4'd3, 1'b0, 32'd1, 32'd2, 32'h0, 5'd0, 5'd8);
      edge1();
      #1 stall = 1'b1;
      ex_mem_reg_write = 1'b1; ex_mem_write_register = 5'd8; ex_mem_alu_result = 32'hAA;
      mem_wb_reg_write = 1'b1; mem_wb_write_register = 5'd8; mem_wb_write_data = 32'hBB;
      #1 chk("fwd_both", ex_a, fwd ? 32'hAA : 32'h1);
      edge1();
      ex_mem_reg_write = 1'b0;
      #1 chk("fwd_memwb", ex_a, fwd ? 32'hBB : 32'h1);
      edge1();
      ex_mem_reg_write = 1'b1; ex_mem_write_register = 5'd0;
      mem_wb_write_register = 5'd0;
      #1 chk("fwd_r0", ex_a, 32'h1);
      // rt = 9 forwarded from MEM/WB into store data and B.
      mem_wb_write_register = 5'd9;
      #1 chk("fwd_rt_b", ex_b, fwd ? 32'hBB : 32'h2);
      edge1();
      ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0;

      // Asynchronous reset between edges during a held SUB.
      #1 stall = 1'b0;
      load(4'd4, 1'b0, 32'd20, 32'd6, 32'h0, 5'd0, 5'd1);
      edge1();
      #1 stall = 1'b1;
      edge1();
      #1 reset = 1'b0;
      #1;
      chk("areset_valid", N'(ex_valid), 0);
      chk("areset_op", N'(ex_alu_operation), 0);
      chk("areset_a", ex_a, 0);
      chk("areset_rw", N'(ex_reg_write), 0);
      edge1();
      #1 reset = 1'b1; stall = 1'b0;
      load(4'd3, 1'b0, 32'd1, 32'd1, 32'h0, 5'd0, 5'd1);
      id_valid = 1'b0; id_mem_write = 1'b1;
      edge1();
      chk("invalid_mw", N'(ex_mem_write), 0);
      chk("invalid_rw", N'(ex_reg_write), 0);
      #1 id_valid = 1'b1;
      edge1();
      chk("valid_mw", N'(ex_mem_write), 1);
      edge1();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
